// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor: diff = a - b - bin, LSD first, sign-magnitude result.
// Optional input-digit validity check is built when BCD_SUB_DIGIT_CHECK_EN is defined.
module bcd_serial_subtractor #(
    parameter int NDIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NDIGITS-1:0] a,
    input  logic [4*NDIGITS-1:0] b,
    input  logic                 bin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NDIGITS-1:0] diff,
    output logic                 neg,
    output logic                 err
);
    localparam int W    = 4 * NDIGITS;
    localparam int IDXW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // One decimal digit of x - y - bw; returns {borrow_out, digit}.
    function automatic logic [4:0] digit_sub(input logic [3:0] x, input logic [3:0] y,
                                             input logic bw);
        logic [4:0] t;
        t = {1'b0, x} - {1'b0, y} - {4'd0, bw};
        if (t[4]) begin
            digit_sub = {1'b1, t[3:0] + 4'd10};
        end else begin
            digit_sub = {1'b0, t[3:0]};
        end
    endfunction

`ifdef BCD_SUB_DIGIT_CHECK_EN
    // 1 if any 4-bit digit of the packed operand exceeds 9.
    function automatic logic has_bad_digit(input logic [W-1:0] x);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (x[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        has_bad_digit = bad;
    endfunction
`endif

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    res_q, res_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            borrow_q, borrow_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [W-1:0]    diff_q, diff_d;
    logic            neg_q, neg_d;
`ifdef BCD_SUB_DIGIT_CHECK_EN
    logic            err_pending_q, err_pending_d;
    logic            err_q, err_d;
`endif

    logic [IDXW+1:0] sel_s;
    logic [4:0]      dig_s;

    assign sel_s = {idx_q, 2'b00};

    // Next-state and datapath: one digit per cycle in SUB, then optional tens-complement in FIX.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        diff_d   = diff_q;
        neg_d    = neg_q;
        dig_s    = 5'd0;
`ifdef BCD_SUB_DIGIT_CHECK_EN
        err_pending_d = err_pending_q;
        err_d         = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    idx_d    = '0;
                    borrow_d = bin;
                    busy_d   = 1'b1;
                    state_d  = SUB;
`ifdef BCD_SUB_DIGIT_CHECK_EN
                    err_pending_d = has_bad_digit(a) | has_bad_digit(b);
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SUB: begin
                dig_s = digit_sub(a_q[sel_s +: 4], b_q[sel_s +: 4], borrow_q);
                res_d[sel_s +: 4] = dig_s[3:0];
                if (idx_q == LAST_IDX) begin
                    if (dig_s[4]) begin
                        // Negative: re-walk the stored digits to form 10^N - res.
                        state_d  = FIX;
                        idx_d    = '0;
                        borrow_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        diff_d  = res_d;
                        neg_d   = 1'b0;
`ifdef BCD_SUB_DIGIT_CHECK_EN
                        err_d = err_pending_q;
`endif
                    end
                end else begin
                    idx_d    = idx_q + IDXW'(1);
                    borrow_d = dig_s[4];
                end
            end
            FIX: begin
                dig_s = digit_sub(4'd0, res_q[sel_s +: 4], borrow_q);
                res_d[sel_s +: 4] = dig_s[3:0];
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    diff_d  = res_d;
                    neg_d   = 1'b1;
`ifdef BCD_SUB_DIGIT_CHECK_EN
                    err_d = err_pending_q;
`endif
                end else begin
                    idx_d    = idx_q + IDXW'(1);
                    borrow_d = dig_s[4];
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            neg_q    <= 1'b0;
`ifdef BCD_SUB_DIGIT_CHECK_EN
            err_pending_q <= 1'b0;
            err_q         <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            neg_q    <= neg_d;
`ifdef BCD_SUB_DIGIT_CHECK_EN
            err_pending_q <= err_pending_d;
            err_q         <= err_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign neg  = neg_q;
`ifdef BCD_SUB_DIGIT_CHECK_EN
    assign err  = err_q;
`else
    assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Bench for bcd_serial_subtractor: integer-arithmetic reference model checked every cycle,
// plus directed vectors with literal expected results and latencies.
module tb_bcd_serial_subtractor;
    localparam int N = 4;
    localparam int W = 4 * N;
    localparam longint TEN_N = 64'd10000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         bin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, neg, err;
    logic [W-1:0] diff;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    bcd_serial_subtractor #(.NDIGITS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .neg(neg), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic longint bcd_val(input logic [W-1:0] x);
        longint v = 0;
        for (int i = N - 1; i >= 0; i--) v = v * 10 + longint'(x[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [W-1:0] to_bcd(input longint v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic any_bad(input logic [W-1:0] x);
        logic r = 1'b0;
        for (int i = 0; i < N; i++) if (x[4*i +: 4] > 4'd9) r = 1'b1;
        return r;
    endfunction

    // Reference model state
    int           rem = 0;
    logic         m_busy = 1'b0, m_done = 1'b0, m_neg = 1'b0, m_err = 1'b0, m_chk = 1'b1;
    logic [W-1:0] m_diff = '0;
    logic         p_neg = 1'b0, p_err = 1'b0, p_chk = 1'b1;
    logic [W-1:0] p_diff = '0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial forever begin
        logic   ob;
        longint v;
        @(posedge clk);
        if (rst) begin
            rem = 0; m_busy = 0; m_done = 0; m_diff = '0; m_neg = 0; m_err = 0; m_chk = 1;
        end else begin
            ob = m_busy;
            m_done = 0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    m_done = 1; m_busy = 0;
                    m_diff = p_diff; m_neg = p_neg; m_err = p_err; m_chk = p_chk;
                end
            end
            if (start && !ob) begin
                v = bcd_val(a) - bcd_val(b) - longint'(bin);
                p_neg  = (v < 0);
                p_diff = to_bcd(((v < 0) ? -v : v) % TEN_N);
                p_chk  = !(any_bad(a) || any_bad(b));
`ifdef BCD_SUB_DIGIT_CHECK_EN
                p_err  = !p_chk;
`else
                p_err  = 1'b0;
`endif
                rem    = p_neg ? 2 * N : N;
                m_busy = 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("err", 64'(err), 64'(m_err));
        if (m_chk) begin
            chk("diff", 64'(diff), 64'(m_diff));
            chk("neg", 64'(neg), 64'(m_neg));
        end
    end

    task automatic wait_done(output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin
                at = cyc;
                break;
            end
            @(negedge clk);
        end
        if (at < 0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    // Issue one operation (optionally in the current cycle) and pin result and latency.
    task automatic do_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tbin, input logic [W-1:0] ediff, input logic eneg,
                         input int elat, input logic now);
        int k, at;
        if (!now) @(negedge clk);
        a = ta; b = tb_; bin = tbin; start = 1'b1; k = cyc;
        @(negedge clk);
        start = 1'b0;
        wait_done(at);
        chk({nm, "_lat"}, 64'(at - k), 64'(elat));
        chk({nm, "_diff"}, 64'(diff), 64'(ediff));
        chk({nm, "_neg"}, 64'(neg), 64'(eneg));
    endtask

    initial begin
        int k, at;
        logic saw;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0;

        do_op("v5432m1234", 16'h5432, 16'h1234, 1'b0, 16'h4198, 1'b0, 5, 1'b0);
        do_op("v1234m5432", 16'h1234, 16'h5432, 1'b0, 16'h4198, 1'b1, 9, 1'b0);
        do_op("ripple",     16'h7000, 16'h6999, 1'b1, 16'h0000, 1'b0, 5, 1'b0);
        do_op("min_neg",    16'h0000, 16'h9999, 1'b1, 16'h0000, 1'b1, 9, 1'b0);
        do_op("minus_one",  16'h0000, 16'h0001, 1'b0, 16'h0001, 1'b1, 9, 1'b0);
        do_op("plus_one",   16'h0100, 16'h0099, 1'b0, 16'h0001, 1'b0, 5, 1'b0);

        // Start while busy must be ignored
        @(negedge clk);
        a = 16'h5432; b = 16'h1234; bin = 1'b0; start = 1'b1; k = cyc;
        @(negedge clk); start = 1'b0;
        @(negedge clk); a = 16'h9999; b = 16'h0000; start = 1'b1;
        @(negedge clk); start = 1'b0; a = '0; b = '0;
        wait_done(at);
        chk("ign_lat", 64'(at - k), 64'd5);
        chk("ign_diff", 64'(diff), 64'h4198);

        // Back-to-back: second start in the done cycle
        do_op("b2b_first",  16'h0500, 16'h0250, 1'b0, 16'h0250, 1'b0, 5, 1'b1);
        do_op("b2b_second", 16'h3000, 16'h0001, 1'b1, 16'h2998, 1'b0, 5, 1'b1);

        // Reset in the middle of FIX
        @(negedge clk);
        a = 16'h1234; b = 16'h5432; bin = 1'b0; start = 1'b1; k = cyc;
        @(negedge clk); start = 1'b0;
        while (cyc < k + 6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("rstfix_busy", 64'(busy), 64'd0);
        chk("rstfix_diff", 64'(diff), 64'd0);
        chk("rstfix_neg", 64'(neg), 64'd0);
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) saw = 1'b1;
        end
        chk("rstfix_nodone", 64'(saw), 64'd0);

        // Invalid digit in a
        @(negedge clk);
        a = 16'h12A4; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(at);
`ifdef BCD_SUB_DIGIT_CHECK_EN
        chk("bad_digit_err", 64'(err), 64'd1);
`else
        chk("bad_digit_err", 64'(err), 64'd0);
`endif
        do_op("after_bad", 16'h0042, 16'h0042, 1'b0, 16'h0000, 1'b0, 5, 1'b0);
        chk("after_bad_err", 64'(err), 64'd0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
